// File: rtl/ldpc_pkg.sv
// Shared definitions for the QC-LDPC datapath: default sizes, the null
// circulant code and the chunk-index helper used by the rotate stages.
package ldpc_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned D_DEF       = 5;
    localparam int unsigned SHIFT_W_DEF = 8;

    // All-ones shift code marks a null circulant (default shift width).
    localparam logic [SHIFT_W_DEF-1:0] NULL_CODE = '1;

    // Source chunk index for output chunk i when rotating by s chunks.
    // dir=0 rotates toward chunk 0, dir=1 toward chunk d-1.
    function automatic int unsigned rot_idx(
        input int unsigned i,
        input int unsigned s,
        input logic        dir,
        input int unsigned d
    );
        int unsigned sm;
        sm = s % d;
        if (dir) begin
            return (i + d - sm) % d;
        end
        return (i + sm) % d;
    endfunction

endpackage

// File: rtl/ldpc_rot_stage.sv
// One registered log-shifter stage: optionally rotates a pair of vectors by a
// fixed AMT chunks in the selected direction, holding when en is low.
module ldpc_rot_stage
    import ldpc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned D      = D_DEF,
    parameter int unsigned AMT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                dir,
    input  logic                sel,
    input  logic                src_valid,
    input  logic [DATA_W*D-1:0] src_a,
    input  logic [DATA_W*D-1:0] src_b,
    output logic                dst_valid,
    output logic [DATA_W*D-1:0] dst_a,
    output logic [DATA_W*D-1:0] dst_b
);

    localparam int unsigned VW = DATA_W * D;

    logic [VW-1:0] rot_a;
    logic [VW-1:0] rot_b;

    // Rotated copies of both vectors; bypassed when this stage's shift bit is 0
    always_comb begin
        rot_a = '0;
        rot_b = '0;
        for (int unsigned i = 0; i < D; i++) begin
            if (!sel) begin
                rot_a[i*DATA_W +: DATA_W] = src_a[i*DATA_W +: DATA_W];
                rot_b[i*DATA_W +: DATA_W] = src_b[i*DATA_W +: DATA_W];
            end else if (dir) begin
                rot_a[i*DATA_W +: DATA_W] = src_a[rot_idx(i, AMT, 1'b1, D)*DATA_W +: DATA_W];
                rot_b[i*DATA_W +: DATA_W] = src_b[rot_idx(i, AMT, 1'b1, D)*DATA_W +: DATA_W];
            end else begin
                rot_a[i*DATA_W +: DATA_W] = src_a[rot_idx(i, AMT, 1'b0, D)*DATA_W +: DATA_W];
                rot_b[i*DATA_W +: DATA_W] = src_b[rot_idx(i, AMT, 1'b0, D)*DATA_W +: DATA_W];
            end
        end
    end

    // Stage register: advances (including bubbles) only when the pipe moves
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_valid <= 1'b0;
            dst_a     <= '0;
            dst_b     <= '0;
        end else if (en) begin
            dst_valid <= src_valid;
            dst_a     <= rot_a;
            dst_b     <= rot_b;
        end
    end

endmodule

// File: rtl/ldpc_cyc_shift_pipe.sv
// Pipelined cyclic shifter between variable-node and check-node units.
// Rotates vtc -> c and ctv -> v by a circulant shift with valid/ready flow
// control; null and out-of-range codes produce the null pattern.
module ldpc_cyc_shift_pipe
    import ldpc_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned D       = D_DEF,
    parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SHIFT_W-1:0]  shift,
    input  logic                dir,
    input  logic [DATA_W*D-1:0] vtc,
    input  logic [DATA_W*D-1:0] ctv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W*D-1:0] c,
    output logic [DATA_W*D-1:0] v,
    output logic                err
);

    localparam int unsigned STG  = $clog2(D);
    localparam int unsigned VW   = DATA_W * D;
    localparam int unsigned SELW = STG * (STG + 1) / 2;
    localparam logic [SHIFT_W-1:0] NULL_SHIFT = '1;
    localparam logic [SHIFT_W-1:0] D_CODE     = SHIFT_W'(D);

    // Shift bits are kept in a triangular store: pipeline position p only
    // carries bits p..STG-1, since earlier bits have already been applied.
    function automatic int unsigned sel_off(input int unsigned p);
        return p * STG - (p * (p - 1)) / 2;
    endfunction

    logic           adv;
    logic           is_null;
    logic           is_bad;
    logic [STG-1:0] shift_eff;

    logic           cap_valid;
    logic [VW-1:0]  cap_a;
    logic [VW-1:0]  cap_b;
    logic [SELW-1:0] sel_q;
    logic [STG-1:0] dir_q;

    logic [STG:0]   pv;
    logic [VW-1:0]  pa [0:STG];
    logic [VW-1:0]  pb [0:STG];

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign is_null   = (shift == NULL_SHIFT);
    assign is_bad    = !is_null && (shift >= D_CODE);
    assign shift_eff = (is_null || is_bad) ? '0 : shift[STG-1:0];

    // Input capture; null/illegal beats are replaced by uniform vectors,
    // which every later rotation leaves unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_valid <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
        end else if (adv) begin
            cap_valid <= in_valid;
            cap_a     <= (is_null || is_bad) ? '1 : vtc;
            cap_b     <= (is_null || is_bad) ? '0 : ctv;
        end
    end

    // Shift bits and direction travel alongside the data through the stages
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            dir_q <= '0;
        end else if (adv) begin
            dir_q[0] <= dir;
            for (int unsigned j = 0; j < STG; j++) begin
                sel_q[j] <= shift_eff[j];
            end
            for (int unsigned p = 1; p < STG; p++) begin
                dir_q[p] <= dir_q[p-1];
                for (int unsigned j = p; j < STG; j++) begin
                    sel_q[sel_off(p) + j - p] <= sel_q[sel_off(p-1) + j - p + 1];
                end
            end
        end
    end

    // Sticky flag for any accepted out-of-range shift code
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (in_valid && adv && is_bad) begin
            err <= 1'b1;
        end
    end

    assign pv[0] = cap_valid;
    assign pa[0] = cap_a;
    assign pb[0] = cap_b;

    for (genvar k = 0; k < STG; k++) begin : g_stage
        ldpc_rot_stage #(
            .DATA_W (DATA_W),
            .D      (D),
            .AMT    (2 ** k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .dir       (dir_q[k]),
            .sel       (sel_q[sel_off(k)]),
            .src_valid (pv[k]),
            .src_a     (pa[k]),
            .src_b     (pb[k]),
            .dst_valid (pv[k+1]),
            .dst_a     (pa[k+1]),
            .dst_b     (pb[k+1])
        );
    end

    assign out_valid = pv[STG];
    assign c         = pa[STG];
    assign v         = pb[STG];

endmodule

// File: tb/tb_ldpc_cyc_shift_pipe.sv
// Directed bench for ldpc_cyc_shift_pipe (DATA_W=8, D=5, SHIFT_W=8).
module tb_ldpc_cyc_shift_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  shift;
    logic        dir;
    logic [39:0] vtc;
    logic [39:0] ctv;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] c;
    logic [39:0] v;
    logic        err;

    int checks = 0;
    int errors = 0;

    localparam logic [39:0] VTC  = 40'h44_33_22_11_00;
    localparam logic [39:0] CTV  = 40'h0E_0D_0C_0B_0A;
    localparam logic [39:0] ONES = 40'hFF_FF_FF_FF_FF;

    // Hand-computed dir=0 rotations of VTC/CTV for shifts 0..4
    localparam logic [39:0] SC [0:4] = '{
        40'h44_33_22_11_00, 40'h00_44_33_22_11, 40'h11_00_44_33_22,
        40'h22_11_00_44_33, 40'h33_22_11_00_44
    };
    localparam logic [39:0] SV [0:4] = '{
        40'h0E_0D_0C_0B_0A, 40'h0A_0E_0D_0C_0B, 40'h0B_0A_0E_0D_0C,
        40'h0C_0B_0A_0E_0D, 40'h0D_0C_0B_0A_0E
    };

    ldpc_cyc_shift_pipe #(
        .DATA_W  (8),
        .D       (5),
        .SHIFT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift     (shift),
        .dir       (dir),
        .vtc       (vtc),
        .ctv       (ctv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .v         (v),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One isolated beat: checks acceptance, 3-cycle latency, data and err
    task automatic run_beat(input string tag, input logic [7:0] s, input logic d,
                            input logic [39:0] ec, input logic [39:0] ev, input logic ee);
        @(negedge clk);
        in_valid  = 1'b1;
        shift     = s;
        dir       = d;
        out_ready = 1'b1;
        #1;
        check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        shift    = 8'h00;
        dir      = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_eq({tag, "_lat"}, 64'(out_valid), 64'(i == 3));
        end
        check_eq({tag, "_c"}, 64'(c), 64'(ec));
        check_eq({tag, "_v"}, 64'(v), 64'(ev));
        check_eq({tag, "_err"}, 64'(err), 64'(ee));
    endtask

    // Back-to-back beats shift=0..4 dir=0, optional 4-cycle downstream stall
    task automatic run_stream(input bit stall);
        int sent;
        int got;
        int exp_cyc;
        bit stalled;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            stalled   = stall && cyc >= 5 && cyc <= 8;
            out_ready = !stalled;
            in_valid  = (sent < 5);
            shift     = 8'(sent);
            dir       = 1'b0;
            #1;
            if (stalled) begin
                check_eq("stall_rdy", 64'(in_ready), 64'd0);
                check_eq("stall_vld", 64'(out_valid), 64'd1);
                check_eq("stall_c", 64'(c), 64'(SC[1]));
                check_eq("stall_v", 64'(v), 64'(SV[1]));
            end
            if (out_valid && out_ready) begin
                exp_cyc = (stall && got > 0) ? got + 8 : got + 4;
                check_eq("seq_c", 64'(c), 64'(SC[got]));
                check_eq("seq_v", 64'(v), 64'(SV[got]));
                check_eq("seq_cyc", 64'(cyc), 64'(exp_cyc));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        check_eq("seq_cnt", 64'(got), 64'd5);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("seq_drain", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_eq("seq_drain2", 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        shift     = 8'h00;
        dir       = 1'b0;
        out_ready = 1'b1;
        vtc       = VTC;
        ctv       = CTV;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_vld", 64'(out_valid), 64'd0);
        check_eq("rst_c", 64'(c), 64'd0);
        check_eq("rst_v", 64'(v), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_rdy", 64'(in_ready), 64'd1);

        run_beat("s2r", 8'd2, 1'b0, SC[2], SV[2], 1'b0);
        run_beat("s1l", 8'd1, 1'b1, 40'h33_22_11_00_44, 40'h0D_0C_0B_0A_0E, 1'b0);
        run_beat("s0r", 8'd0, 1'b0, VTC, CTV, 1'b0);
        run_beat("s0l", 8'd0, 1'b1, VTC, CTV, 1'b0);
        run_beat("s4l", 8'd4, 1'b1, 40'h00_44_33_22_11, 40'h0A_0E_0D_0C_0B, 1'b0);
        run_beat("s3l", 8'd3, 1'b1, 40'h11_00_44_33_22, 40'h0B_0A_0E_0D_0C, 1'b0);
        run_beat("nulr", 8'hFF, 1'b0, ONES, 40'h0, 1'b0);
        run_beat("null", 8'hFF, 1'b1, ONES, 40'h0, 1'b0);

        run_stream(1'b0);
        run_stream(1'b1);

        run_beat("bad7", 8'd7, 1'b0, ONES, 40'h0, 1'b1);
        run_beat("keep", 8'd3, 1'b0, SC[3], SV[3], 1'b1);
        run_beat("bad5", 8'd5, 1'b1, ONES, 40'h0, 1'b1);

        // Reset with two beats in flight
        @(negedge clk);
        in_valid = 1'b1;
        shift    = 8'd1;
        dir      = 1'b0;
        @(negedge clk);
        shift = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_vld", 64'(out_valid), 64'd0);
        check_eq("mrst_c", 64'(c), 64'd0);
        check_eq("mrst_err", 64'(err), 64'd0);
        check_eq("mrst_rdy", 64'(in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mrst_hold", 64'(out_valid), 64'd0);
        end
        run_beat("post", 8'd3, 1'b0, SC[3], SV[3], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ldpc_cyc_shift_pipe.md
Name: ldpc_cyc_shift_pipe

Overview:
- Pipelined, parametrised cyclic shifter for the QC-LDPC decoder datapath. It sits between the variable-node and check-node units.
- Rotates one variable-to-check vector and one check-to-variable vector per beat by a circulant shift value.
- Generalises the combinational shifter:
  - adds a rotate-direction select and a log-stage register pipeline;
  - adds a valid/ready handshake with backpressure;
  - adds out-of-range shift detection.

Parameters:
- DATA_W, 8, width of one message chunk (bits).
- D, 5, lifting size; number of chunks per vector (D >= 2).
- SHIFT_W, 8, width of the shift code; all-ones is the null-circulant code.
- STG, clog2(D), number of rotate stages and pipeline latency in cycles (derived localparam).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- shift  in  SHIFT_W  circulant shift value, or the null code (all ones).
- dir  in  1  0 = rotate toward chunk 0 (right); 1 = rotate toward chunk D-1 (left).
- vtc  in  DATA_W*D  variable-to-check vector; chunk k is bits [k*DATA_W +: DATA_W].
- ctv  in  DATA_W*D  check-to-variable vector; same chunk layout.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- c  out  DATA_W*D  rotated vtc.
- v  out  DATA_W*D  rotated ctv.
- err  out  1  sticky: set when an out-of-range shift was accepted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits, out_valid, c, v and err clear to 0;
  - in_ready is 1 in the cycle after reset.
  - A reset mid-operation drops every in-flight beat; no partial output is emitted.
- Rotation, for a legal shift s with 0 <= s < D:
  - dir=0: c chunk i = vtc chunk (i+s) mod D.
  - dir=1: c chunk i = vtc chunk (i-s+D) mod D.
  - v is formed from ctv identically.
- Null code: shift = all ones → c = all ones and v = all zeros, whatever dir is.
- Illegal code: D <= shift < all-ones → beat is output as the null pattern and err is set. err stays set until rst.
- Pipeline:
  - Stage k (k = 0..STG-1) rotates by 2^k chunks (mod D) in direction dir when bit k of the captured shift is 1.
  - Shift value, dir and the null/illegal flag travel with the data.
  - Composing the stage rotations gives rotation by s mod D; this is exact because s < D.
- Latency: exactly STG cycles from an accepted input (in_valid & in_ready at an edge) to out_valid, when there is no stall.
- Handshake:
  - Global advance enable: adv = !out_valid | out_ready. in_ready = adv.
  - When adv=0, all stages hold. c, v and out_valid stay stable until out_ready.
  - Bubbles propagate: a stage with valid=0 shifts its valid=0 forward.
  - Throughput is one beat per cycle when out_ready stays at 1.
- Simultaneous events:
  - An accept and an emit in the same cycle are both performed.
  - rst takes priority over any handshake.
- Data registers of invalid stages may hold stale values. c and v are defined only while out_valid=1; they read 0 after reset.

Decomposition:
- Shared package ldpc_pkg holds:
  - the null-code constant (all ones of SHIFT_W);
  - the chunk-index helper function rot_idx(i, s, dir, D);
  - the DATA_W and D defaults shared with the node units.
- One sub-module, ldpc_rot_stage:
  - parameters DATA_W, D, AMT;
  - registered rotate-by-AMT-chunks with direction input and enable;
  - instantiated STG times by a generate loop, with AMT = 2^k.

Test Plan (DATA_W=8, D=5, STG=3, vtc = 40'h44_33_22_11_00, ctv = 40'h0E_0D_0C_0B_0A):
- shift=2, dir=0, out_ready=1 → after 3 cycles out_valid=1, c=40'h11_00_44_33_22, v=40'h0B_0A_0E_0D_0C.
- shift=1, dir=1 → c=40'h33_22_11_00_44, v=40'h0D_0C_0B_0A_0E. Also shift=0 → c=vtc, v=ctv.
- shift=8'hFF, either dir → c=40'hFF_FF_FF_FF_FF, v=0, err stays 0.
- shift=7 → null pattern output, err=1, and err stays 1 through later legal beats until rst.
- Back-to-back beats shift=0..4 with out_ready=1:
  - 5 consecutive outputs in order, one per cycle;
  - then hold out_ready=0 for 4 cycles → in_ready=0, c and v stable, no beat lost or duplicated.
- Assert rst with 2 beats in flight → out_valid=0 next cycle and stays 0. The next accepted beat appears exactly 3 cycles after its accept.
